// File: rtl/sample_buf_pkg.sv
// Shared widths, sample payload and output-queue state encoding for the
// sample buffer controller.
package sample_buf_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 16;
    localparam int unsigned DEF_PAR_WIDTH  = 2;
    localparam int unsigned DEF_ADDR_WIDTH = 10;

    typedef struct packed {
        logic [DEF_PAR_WIDTH-1:0]  par;
        logic [DEF_DATA_WIDTH-1:0] data;
    } sample_t;

    // Encodings equal the number of held entries.
    typedef enum logic [1:0] {
        Q_EMPTY = 2'd0,
        Q_ONE   = 2'd1,
        Q_TWO   = 2'd2
    } q_state_t;

endpackage

// File: rtl/sample_buf_ctrl_out_skid_q.sv
// Two-entry output queue between the RAM read port and the valid/ready
// stream; the head register always drives the output data.
module out_skid_q
    import sample_buf_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_DATA_WIDTH + DEF_PAR_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic [1:0]       o_occ
);

    q_state_t         r_state;
    q_state_t         w_state_nxt;
    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_tail;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= Q_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (i_push && !i_pop) begin
            case (r_state)
                Q_EMPTY: w_state_nxt = Q_ONE;
                Q_ONE:   w_state_nxt = Q_TWO;
                default: w_state_nxt = r_state;
            endcase
        end else if (i_pop && !i_push) begin
            case (r_state)
                Q_TWO:   w_state_nxt = Q_ONE;
                Q_ONE:   w_state_nxt = Q_EMPTY;
                default: w_state_nxt = r_state;
            endcase
        end
    end

    always_comb begin
        o_valid = 1'b0;
        o_occ   = 2'd0;
        case (r_state)
            Q_ONE: begin
                o_valid = 1'b1;
                o_occ   = 2'd1;
            end
            Q_TWO: begin
                o_valid = 1'b1;
                o_occ   = 2'd2;
            end
            default: begin
                o_valid = 1'b0;
                o_occ   = 2'd0;
            end
        endcase
    end

    // Head only moves on a pop or a push into an empty slot, so it holds while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            if (i_pop && (r_state == Q_TWO)) begin
                r_head <= r_tail;
            end else if (i_push && ((r_state == Q_EMPTY) || ((r_state == Q_ONE) && i_pop))) begin
                r_head <= i_data;
            end
            if (i_push && (((r_state == Q_ONE) && !i_pop) || ((r_state == Q_TWO) && i_pop))) begin
                r_tail <= i_data;
            end
        end
    end

    assign o_data = r_head;

endmodule

// File: rtl/sample_buf_ctrl.sv
// Circular-buffer controller for an external 1024x18 dual-port sample RAM:
// port A takes the acquisition stream, port B prefetches into a 2-entry queue.
module sample_buf_ctrl
    import sample_buf_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned PAR_WIDTH  = DEF_PAR_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  IN_VALID,
    input  logic [DATA_WIDTH-1:0] IN_DATA,
    input  logic [PAR_WIDTH-1:0]  IN_PAR,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    output logic [DATA_WIDTH-1:0] OUT_DATA,
    output logic [PAR_WIDTH-1:0]  OUT_PAR,
    output logic                  RAM_ENA,
    output logic                  RAM_WEA,
    output logic [ADDR_WIDTH-1:0] RAM_ADDRA,
    output logic [DATA_WIDTH-1:0] RAM_DIA,
    output logic [PAR_WIDTH-1:0]  RAM_DIPA,
    output logic                  RAM_ENB,
    output logic                  RAM_WEB,
    output logic [DATA_WIDTH-1:0] RAM_DIB,
    output logic [PAR_WIDTH-1:0]  RAM_DIPB,
    output logic [ADDR_WIDTH-1:0] RAM_ADDRB,
    input  logic [DATA_WIDTH-1:0] RAM_DOB,
    input  logic [PAR_WIDTH-1:0]  RAM_DOPB,
    output logic [ADDR_WIDTH:0]   COUNT,
    output logic                  FULL,
    output logic                  EMPTY,
    output logic                  OVERFLOW,
    input  logic                  CLR_OVF
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned SW    = DATA_WIDTH + PAR_WIDTH;
    localparam int unsigned CW    = ADDR_WIDTH + 1;

    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic [CW-1:0]         w_count_nxt;
    logic                  r_inflight;
    logic                  r_full;
    logic                  r_empty;
    logic                  r_ovf;
    logic                  w_wr_acc;
    logic                  w_drop;
    logic                  w_pop;
    logic                  w_rd_issue;
    logic                  w_q_valid;
    logic [1:0]            w_q_occ;
    logic [2:0]            w_credit;
    logic [SW-1:0]         w_q_data;

    // Write strobe is gated by reset so port A stays quiet while RST_N is low.
    assign w_wr_acc = RST_N && IN_VALID && !r_full;
    assign w_drop   = IN_VALID && r_full;
    assign w_pop    = w_q_valid && OUT_READY;

    // Occupancy the queue will reach once the outstanding read lands; never exceeds 2.
    assign w_credit    = 3'(w_q_occ) + 3'(r_inflight) - 3'(w_pop);
    assign w_rd_issue  = (r_count != '0) && (w_credit < 3'd2);
    assign w_count_nxt = r_count + CW'(w_wr_acc) - CW'(w_rd_issue);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_inflight <= 1'b0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_ovf      <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
            end
            if (w_rd_issue) begin
                r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
            end
            r_inflight <= w_rd_issue;
            r_count    <= w_count_nxt;
            r_full     <= (w_count_nxt == CW'(DEPTH));
            r_empty    <= (w_count_nxt == '0);
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (CLR_OVF) begin
                r_ovf <= 1'b0;
            end
        end
    end

    out_skid_q #(
        .WIDTH (SW)
    ) u_out_q (
        .clk     (CLK),
        .rst_n   (RST_N),
        .i_push  (r_inflight),
        .i_data  ({RAM_DOPB, RAM_DOB}),
        .i_pop   (w_pop),
        .o_valid (w_q_valid),
        .o_data  (w_q_data),
        .o_occ   (w_q_occ)
    );

    assign OUT_VALID           = w_q_valid;
    assign {OUT_PAR, OUT_DATA} = w_q_data;

    assign RAM_ENA   = w_wr_acc;
    assign RAM_WEA   = w_wr_acc;
    assign RAM_ADDRA = r_wr_ptr;
    assign RAM_DIA   = IN_DATA;
    assign RAM_DIPA  = IN_PAR;
    assign RAM_ENB   = w_rd_issue;
    assign RAM_WEB   = 1'b0;
    assign RAM_DIB   = '0;
    assign RAM_DIPB  = '0;
    assign RAM_ADDRB = r_rd_ptr;

    assign COUNT    = r_count;
    assign FULL     = r_full;
    assign EMPTY    = r_empty;
    assign OVERFLOW = r_ovf;

endmodule

// File: tb/tb_sample_buf_ctrl.sv
// Directed bench for sample_buf_ctrl with a behavioural 1024x18 RAM beside it
// and an in-order scoreboard of accepted samples.
module tb_sample_buf_ctrl;
    import sample_buf_pkg::*;

    localparam int unsigned DW = 16;
    localparam int unsigned PW = 2;
    localparam int unsigned AW = 10;

    logic          CLK;
    logic          RST_N;
    logic          IN_VALID;
    logic [DW-1:0] IN_DATA;
    logic [PW-1:0] IN_PAR;
    logic          OUT_VALID;
    logic          OUT_READY;
    logic [DW-1:0] OUT_DATA;
    logic [PW-1:0] OUT_PAR;
    logic          RAM_ENA;
    logic          RAM_WEA;
    logic [AW-1:0] RAM_ADDRA;
    logic [DW-1:0] RAM_DIA;
    logic [PW-1:0] RAM_DIPA;
    logic          RAM_ENB;
    logic          RAM_WEB;
    logic [DW-1:0] RAM_DIB;
    logic [PW-1:0] RAM_DIPB;
    logic [AW-1:0] RAM_ADDRB;
    logic [DW-1:0] RAM_DOB;
    logic [PW-1:0] RAM_DOPB;
    logic [AW:0]   COUNT;
    logic          FULL;
    logic          EMPTY;
    logic          OVERFLOW;
    logic          CLR_OVF;

    logic [DW+PW-1:0] mem [0:(1<<AW)-1];
    sample_t          sb[$];
    int               n_vec;
    int               n_err;
    logic             stall_pend;
    sample_t          stall_head;
    int               maxc;
    logic             wrapa;
    logic             wrapb;
    logic             seenb;
    logic [AW-1:0]    preva;
    logic [AW-1:0]    prevb;

    sample_buf_ctrl dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .IN_VALID  (IN_VALID),
        .IN_DATA   (IN_DATA),
        .IN_PAR    (IN_PAR),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .OUT_DATA  (OUT_DATA),
        .OUT_PAR   (OUT_PAR),
        .RAM_ENA   (RAM_ENA),
        .RAM_WEA   (RAM_WEA),
        .RAM_ADDRA (RAM_ADDRA),
        .RAM_DIA   (RAM_DIA),
        .RAM_DIPA  (RAM_DIPA),
        .RAM_ENB   (RAM_ENB),
        .RAM_WEB   (RAM_WEB),
        .RAM_DIB   (RAM_DIB),
        .RAM_DIPB  (RAM_DIPB),
        .RAM_ADDRB (RAM_ADDRB),
        .RAM_DOB   (RAM_DOB),
        .RAM_DOPB  (RAM_DOPB),
        .COUNT     (COUNT),
        .FULL      (FULL),
        .EMPTY     (EMPTY),
        .OVERFLOW  (OVERFLOW),
        .CLR_OVF   (CLR_OVF)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Sample RAM: synchronous write on A, registered read on B.
    always @(posedge CLK) begin
        if (RAM_ENA && RAM_WEA) mem[RAM_ADDRA] <= {RAM_DIPA, RAM_DIA};
        if (RAM_ENB) {RAM_DOPB, RAM_DOB} <= mem[RAM_ADDRB];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_vec++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, want);
        end
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic [PW-1:0] p,
                         input logic rdy, input logic clr);
        IN_VALID  = v;
        IN_DATA   = d;
        IN_PAR    = p;
        OUT_READY = rdy;
        CLR_OVF   = clr;
        #1;
    endtask

    // Scoreboard check for the edge about to happen, then advance to the next falling edge.
    task automatic cycle();
        sample_t head;
        sample_t want;
        head = sample_t'({OUT_PAR, OUT_DATA});
        if (stall_pend) chk("stall_hold", 32'(head), 32'(stall_head));
        stall_pend = (OUT_VALID === 1'b1) && (OUT_READY === 1'b0);
        stall_head = head;
        if (OUT_VALID === 1'b1 && OUT_READY === 1'b1) begin
            chk("pop_avail", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                want = sb.pop_front();
                chk("pop_data", 32'(head), 32'(want));
            end
        end
        @(negedge CLK);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        stall_pend = 1'b0;
        stall_head = '0;
        RST_N = 1'b1;
        IN_VALID = 1'b0; IN_DATA = '0; IN_PAR = '0; OUT_READY = 1'b0; CLR_OVF = 1'b0;
        #2 RST_N = 1'b0;
        repeat (3) @(negedge CLK);

        // Reset state
        chk("rst_out_valid", 32'(OUT_VALID), 32'd0);
        chk("rst_out_data",  32'(OUT_DATA),  32'd0);
        chk("rst_out_par",   32'(OUT_PAR),   32'd0);
        chk("rst_count",     32'(COUNT),     32'd0);
        chk("rst_full",      32'(FULL),      32'd0);
        chk("rst_empty",     32'(EMPTY),     32'd1);
        chk("rst_overflow",  32'(OVERFLOW),  32'd0);
        chk("rst_ena",       32'(RAM_ENA),   32'd0);
        chk("rst_wea",       32'(RAM_WEA),   32'd0);
        chk("rst_enb",       32'(RAM_ENB),   32'd0);
        chk("const_web",     32'(RAM_WEB),   32'd0);
        chk("const_dib",     32'({RAM_DIPB, RAM_DIB}), 32'd0);
        RST_N = 1'b1;

        // Single sample latency
        drive(1'b1, 16'h1234, 2'b01, 1'b1, 1'b0);
        chk("single_ena",   32'(RAM_ENA),   32'd1);
        chk("single_wea",   32'(RAM_WEA),   32'd1);
        chk("single_addra", 32'(RAM_ADDRA), 32'd0);
        chk("single_dia",   32'({RAM_DIPA, RAM_DIA}), 32'h11234);
        @(negedge CLK);
        drive(1'b0, 16'h0, 2'b00, 1'b1, 1'b0);
        chk("single_count", 32'(COUNT),     32'd1);
        chk("single_enb",   32'(RAM_ENB),   32'd1);
        chk("single_addrb", 32'(RAM_ADDRB), 32'd0);
        @(negedge CLK);
        chk("single_e1_valid", 32'(OUT_VALID), 32'd0);
        @(negedge CLK);
        chk("single_e2_valid", 32'(OUT_VALID), 32'd1);
        chk("single_e2_data",  32'(OUT_DATA),  32'h1234);
        chk("single_e2_par",   32'(OUT_PAR),   32'd1);
        @(negedge CLK);
        chk("single_e3_valid", 32'(OUT_VALID), 32'd0);
        chk("single_empty",    32'(EMPTY),     32'd1);

        // Streaming with pointer wrap
        maxc = 0; wrapa = 1'b0; wrapb = 1'b0; seenb = 1'b0; preva = RAM_ADDRA; prevb = '0;
        for (int i = 0; i < 3000; i++) begin
            drive(1'b1, 16'(i), 2'(i), 1'b1, 1'b0);
            sb.push_back(sample_t'({2'(i), 16'(i)}));
            if (RAM_ENA && preva == 10'd1023 && RAM_ADDRA == 10'd0) wrapa = 1'b1;
            preva = RAM_ADDRA;
            if (RAM_ENB) begin
                if (seenb && prevb == 10'd1023 && RAM_ADDRB == 10'd0) wrapb = 1'b1;
                prevb = RAM_ADDRB;
                seenb = 1'b1;
            end
            if (int'(COUNT) > maxc) maxc = int'(COUNT);
            cycle();
        end
        drive(1'b0, 16'h0, 2'b00, 1'b1, 1'b0);
        for (int k = 0; k < 8 && sb.size() != 0; k++) cycle();
        chk("stream_drained",   32'(sb.size()), 32'd0);
        chk("stream_wrap_a",    32'(wrapa), 32'd1);
        chk("stream_wrap_b",    32'(wrapb), 32'd1);
        chk("stream_count_max", 32'(maxc <= 2), 32'd1);
        repeat (2) cycle();

        // Fill to full, drop, and overflow clear priority
        for (int i = 0; i < 1030; i++) begin
            drive(1'b1, 16'(i), 2'(i), 1'b0, (i == 1029));
            if (i == 1026) begin
                chk("fill_full",       32'(FULL),     32'd1);
                chk("fill_count",      32'(COUNT),    32'd1024);
                chk("fill_ovf_before", 32'(OVERFLOW), 32'd0);
                chk("fill_ena_full",   32'(RAM_ENA),  32'd0);
            end
            if (i < 1026) sb.push_back(sample_t'({2'(i), 16'(i)}));
            cycle();
        end
        chk("ovf_drop_and_clr", 32'(OVERFLOW), 32'd1);
        chk("fill_head_valid",  32'(OUT_VALID), 32'd1);
        chk("fill_head_data",   32'(OUT_DATA),  32'd0);
        chk("fill_count_hold",  32'(COUNT),     32'd1024);
        drive(1'b0, 16'h0, 2'b00, 1'b0, 1'b1);
        cycle();
        chk("ovf_cleared", 32'(OVERFLOW), 32'd0);
        drive(1'b0, 16'h0, 2'b00, 1'b1, 1'b0);
        for (int k = 0; k < 1100 && sb.size() != 0; k++) cycle();
        chk("fill_drained", 32'(sb.size()), 32'd0);
        repeat (2) cycle();
        chk("fill_end_empty", 32'(EMPTY),     32'd1);
        chk("fill_end_valid", 32'(OUT_VALID), 32'd0);
        chk("fill_end_count", 32'(COUNT),     32'd0);

        // Backpressure: ready toggles every cycle
        for (int i = 0; i < 200; i++) begin
            drive(1'b1, 16'(16'h4000 + i), 2'(i + 1), ((i % 2) == 0), 1'b0);
            sb.push_back(sample_t'({2'(i + 1), 16'(16'h4000 + i)}));
            cycle();
        end
        drive(1'b0, 16'h0, 2'b00, 1'b1, 1'b0);
        for (int k = 0; k < 300 && sb.size() != 0; k++) cycle();
        chk("bp_drained",  32'(sb.size()), 32'd0);
        chk("bp_overflow", 32'(OVERFLOW),  32'd0);

        // Asynchronous reset in the middle of a stream
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 16'(16'h7000 + i), 2'(i), 1'b1, 1'b0);
            sb.push_back(sample_t'({2'(i), 16'(16'h7000 + i)}));
            cycle();
        end
        #2 RST_N = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(OUT_VALID), 32'd0);
        chk("mid_rst_data",  32'({OUT_PAR, OUT_DATA}), 32'd0);
        chk("mid_rst_count", 32'(COUNT),     32'd0);
        chk("mid_rst_empty", 32'(EMPTY),     32'd1);
        chk("mid_rst_full",  32'(FULL),      32'd0);
        chk("mid_rst_ena",   32'(RAM_ENA),   32'd0);
        chk("mid_rst_enb",   32'(RAM_ENB),   32'd0);
        sb.delete();
        stall_pend = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        drive(1'b1, 16'hABCD, 2'b10, 1'b1, 1'b0);
        chk("post_rst_ena",   32'(RAM_ENA),   32'd1);
        chk("post_rst_addra", 32'(RAM_ADDRA), 32'd0);
        sb.push_back(sample_t'({2'b10, 16'hABCD}));
        cycle();
        drive(1'b0, 16'h0, 2'b00, 1'b1, 1'b0);
        for (int k = 0; k < 10 && sb.size() != 0; k++) cycle();
        chk("post_rst_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
